cnt_sched: RTL and testbench
============================

# cnt_sched

Round-robin scheduler that shares one N-bit interval counter among NREQ requesters. Each requester asks for an interval of L counter ticks. The block arbitrates, latches that requester's length, clears and runs the counter for L enabled cycles, then pulses a per-requester completion. It sits between client engines needing timed windows and the shared counting datapath, and replaces ad-hoc free-running counters per client.

## Interface
- NREQ, 4, number of requesters (2..8)
- N, 8, counter and length width in bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester level request; held until done (or abort)
- req_len  in  NREQ*N  interval lengths; requester i uses bits [i*N +: N]
- hold  in  1  pauses counting while high; state and count are frozen
- gnt  out  NREQ  one-hot grant; high from GRANT through DONE
- busy  out  1  high in any state other than IDLE
- done  out  NREQ  one-cycle completion pulse for the granted requester
- aborted  out  NREQ  one-cycle abort pulse (tied 0 unless CNT_SCHED_ABORT_EN)
- count_out  out  N  current interval count

## Operation
- States: IDLE, GRANT, COUNT, DONE.
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, aborted=0, busy=0, count_out=0, latched length=0.
- IDLE: if any req bit is set, select the first set bit at or after ptr, scanning upward mod NREQ. Register the selection as sel and go to GRANT. If no req bit is set, stay in IDLE.
- GRANT (1 cycle): gnt=onehot(sel), count_out cleared to 0, len latched from req_len[sel].
  - len==0 goes to DONE.
  - Otherwise goes to COUNT.
- COUNT, each cycle:
  - hold=1: no change.
  - hold=0 and count_out==len-1: go to DONE, count_out unchanged.
  - Otherwise: count_out increments by 1.
- DONE (1 cycle): done[sel]=1, gnt still asserted. Next state is IDLE, ptr=(sel+1) mod NREQ.
- count_out holds its last value in DONE and IDLE and is cleared only on GRANT.
- req_len changes after GRANT are ignored. Requests other than sel are ignored while busy.
- Counter never wraps: len ≤ 2^N-1 guarantees count_out ≤ 2^N-2.
- rst mid-operation: returns to IDLE, ptr=0, all outputs at reset values next cycle. No done or aborted pulse.

## Timing
- Request seen in IDLE at cycle t:
  - gnt/busy high at t+1.
  - count_out=0..L-1 over t+2..t+L+1 (no hold).
  - done at t+L+2.
  - gnt low at t+L+3.
- Grant-to-done latency is L+1 cycles plus the number of held COUNT cycles.
- Minimum one IDLE cycle between consecutive grants, so back-to-back period is L+3 cycles.
- hold is sampled only in COUNT. It has no effect in IDLE, GRANT or DONE.
- done and aborted are mutually exclusive and one-hot.

## Configuration
- CNT_SCHED_ABORT_EN defined:
  - In GRANT or COUNT, if req[sel]==0 is sampled, the next state is IDLE.
  - In that IDLE cycle, aborted[sel]=1 and gnt=0.
  - ptr=(sel+1) mod NREQ. No done pulse.
  - Abort takes priority over hold and over the DONE transition in the same cycle.
- CNT_SCHED_ABORT_EN undefined:
  - req[sel] is ignored after GRANT and the interval always completes with done.
  - aborted is constant 0.

## Test plan
All scenarios use NREQ=4, N=8.
- Reset: rst=1 for 2 cycles with req=4'b1111 → gnt=0, done=0, aborted=0, busy=0, count_out=0. First grant after release is gnt=4'b0001.
- Single interval: req[0]=1, len0=3 at cycle 0 → gnt=0001 in cycles 1–5, count_out 0,1,2 in cycles 2–4, done=0001 in cycle 5, gnt=0 in cycle 6.
- Round-robin: req=1111, all len=1, held high → grants 0001, 0010, 0100, 1000, 0001, each starting 4 cycles apart. No requester granted twice before the others.
- Zero length: req[2]=1, len2=0 → GRANT in cycle 1, done=0100 in cycle 2, count_out=0.
- Hold: req[0], len=4, hold=1 in cycles 3–4 → count_out 0,1,1,1,2,3 over cycles 2–7, done in cycle 8.
- Abort (macro defined): req[1], len=10, req[1] dropped at cycle 4 → aborted=0010 and gnt=0 in cycle 5, no done. With the macro undefined → done=0010 in cycle 12.

Source files
------------

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler sharing one N-bit interval counter among
// NREQ requesters. A granted requester's length L is latched, the counter is
// cleared and advanced for L non-held cycles, then done pulses for that requester.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester level request, held until done (or abort)
//   req_len    packed interval lengths, requester i uses [i*N +: N]
//   hold       freezes the counter while in COUNT
//   gnt        one-hot grant, high from GRANT through DONE
//   busy       high whenever not IDLE
//   done       one-cycle completion pulse for the granted requester
//   aborted    one-cycle abort pulse (constant 0 unless CNT_SCHED_ABORT_EN)
//   count_out  current interval count
//
// Build option: define CNT_SCHED_ABORT_EN to let a dropped req[sel] during
// GRANT/COUNT abort the interval.
module cnt_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned N    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] req_len,
   input  logic              hold,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   aborted,
   output logic [N-1:0]      count_out
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, sel, sel_nxt, pick_c, ptr_inc_c;
   logic [N-1:0]  len, sel_len_c;
   logic          any_req_c, abort_c, last_c;

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] s);
      onehot = NREQ'(1) << s;
   endfunction

   // First requesting index at or after ptr, scanning upward mod NREQ.
   always_comb begin : pick_blk
      int unsigned idx;
      logic        found;
      pick_c    = ptr;
      found     = 1'b0;
      idx       = 0;
      any_req_c = |req;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[PW'(idx)]) begin
            pick_c = PW'(idx);
            found  = 1'b1;
         end
      end
   end

   // Length of the currently selected requester.
   always_comb begin
      sel_len_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (sel == PW'(i)) sel_len_c = req_len[i*N +: N];
      end
   end

   // Pointer value after servicing sel.
   always_comb begin
      ptr_inc_c = '0;
      if (sel != PW'(NREQ - 1)) ptr_inc_c = sel + PW'(1);
   end

   // Abort fires only on a dropped request of the owner while counting is pending.
   always_comb begin
      abort_c = 1'b0;
`ifdef CNT_SCHED_ABORT_EN
      abort_c = ((state == S_GRANT) || (state == S_COUNT)) && !req[sel];
`endif
   end

   assign last_c = (count_out == len - N'(1));

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      case (state)
         S_IDLE: begin
            if (any_req_c) begin
               state_nxt = S_GRANT;
               sel_nxt   = pick_c;
            end
         end
         S_GRANT: begin
            if (abort_c)                 state_nxt = S_IDLE;
            else if (sel_len_c == '0)    state_nxt = S_DONE;
            else                         state_nxt = S_COUNT;
         end
         S_COUNT: begin
            if (abort_c)                 state_nxt = S_IDLE;
            else if (!hold && last_c)    state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         sel       <= '0;
         len       <= '0;
         count_out <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         done      <= '0;
         aborted   <= '0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         busy    <= (state_nxt != S_IDLE);
         gnt     <= (state_nxt != S_IDLE) ? onehot(sel_nxt) : '0;
         done    <= (state_nxt == S_DONE) ? onehot(sel) : '0;
         aborted <= abort_c ? onehot(sel) : '0;

         if (state == S_GRANT) begin
            len       <= sel_len_c;
            count_out <= '0;
         end else if ((state == S_COUNT) && (state_nxt == S_COUNT) && !hold) begin
            count_out <= count_out + N'(1);
         end

         if ((state == S_DONE) || abort_c) ptr <= ptr_inc_c;
      end
   end

endmodule

// File: tb/tb_cnt_sched.sv
// Directed testbench for cnt_sched (NREQ=4, N=8). Cycle c of a scenario is the
// interval after the c-th rising edge counted from the cycle the request is applied.
module tb_cnt_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] len [4];
   logic [31:0] req_len;
   logic       hold;
   logic [3:0] gnt, done, aborted;
   logic       busy;
   logic [7:0] count_out;

   int checks = 0;
   int errors = 0;

   assign req_len = {len[3], len[2], len[1], len[0]};

   cnt_sched #(.NREQ(4), .N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_len   (req_len),
      .hold      (hold),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .count_out (count_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string name, input int c, input logic [3:0] eg, input logic [3:0] ed);
      check($sformatf("%s c%0d gnt", name, c), 32'(gnt), 32'(eg));
      check($sformatf("%s c%0d done", name, c), 32'(done), 32'(ed));
      check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(eg != 4'b0));
      check($sformatf("%s c%0d aborted", name, c), 32'(aborted), 32'd0);
   endtask

   initial begin
      logic [3:0] exp_g;
      logic [7:0] hold_cnt [6];
      hold_cnt[0] = 8'd0; hold_cnt[1] = 8'd1; hold_cnt[2] = 8'd1;
      hold_cnt[3] = 8'd1; hold_cnt[4] = 8'd2; hold_cnt[5] = 8'd3;

      // Reset with all requests pending.
      rst = 1'b1; req = 4'b1111; hold = 1'b0;
      for (int i = 0; i < 4; i++) len[i] = 8'd1;
      tick(); tick();
      chk_ctl("reset", 0, 4'b0000, 4'b0000);
      check("reset count", 32'(count_out), 32'd0);

      // Round-robin: all len=1, grants every 4 cycles.
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         tick(); chk_ctl("rr", 4*k+1, exp_g, 4'b0000);
         tick(); chk_ctl("rr", 4*k+2, exp_g, 4'b0000);
         check($sformatf("rr c%0d count", 4*k+2), 32'(count_out), 32'd0);
         tick(); chk_ctl("rr", 4*k+3, exp_g, exp_g);
         tick(); chk_ctl("rr", 4*k+4, 4'b0000, 4'b0000);
      end
      req = 4'b0000;
      tick();

      // Single interval, len0=3; later len/req changes must be ignored.
      req = 4'b0001; len[0] = 8'd3;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk_ctl("single", c, (c <= 5) ? 4'b0001 : 4'b0000, (c == 5) ? 4'b0001 : 4'b0000);
         if (c >= 2 && c <= 4) check($sformatf("single c%0d count", c), 32'(count_out), 32'(c - 2));
         if (c == 6) check("single c6 count hold", 32'(count_out), 32'd2);
         if (c == 2) begin len[0] = 8'd200; req = 4'b0011; end
         if (c == 5) req = 4'b0000;
      end
      len[0] = 8'd3;

      // Zero length on requester 2.
      req = 4'b0100; len[2] = 8'd0;
      tick(); chk_ctl("zero", 1, 4'b0100, 4'b0000);
      tick(); chk_ctl("zero", 2, 4'b0100, 4'b0100);
      check("zero c2 count", 32'(count_out), 32'd0);
      req = 4'b0000;
      tick(); chk_ctl("zero", 3, 4'b0000, 4'b0000);

      // Hold in cycles 3-4 stretches the interval by two.
      req = 4'b0001; len[0] = 8'd4;
      for (int c = 1; c <= 9; c++) begin
         tick();
         chk_ctl("hold", c, (c <= 8) ? 4'b0001 : 4'b0000, (c == 8) ? 4'b0001 : 4'b0000);
         if (c >= 2 && c <= 7) check($sformatf("hold c%0d count", c), 32'(count_out), 32'(hold_cnt[c-2]));
         hold = (c == 3 || c == 4);
         if (c == 8) req = 4'b0000;
      end
      hold = 1'b0;

      // Requester 1, len=10, request dropped at cycle 4.
      req = 4'b0010; len[1] = 8'd10;
`ifdef CNT_SCHED_ABORT_EN
      for (int c = 1; c <= 13; c++) begin
         tick();
         check($sformatf("abort c%0d gnt", c), 32'(gnt), 32'((c <= 4) ? 4'b0010 : 4'b0000));
         check($sformatf("abort c%0d done", c), 32'(done), 32'd0);
         check($sformatf("abort c%0d aborted", c), 32'(aborted), 32'((c == 5) ? 4'b0010 : 4'b0000));
         if (c == 4) req = 4'b0000;
      end
`else
      for (int c = 1; c <= 13; c++) begin
         tick();
         chk_ctl("long", c, (c <= 12) ? 4'b0010 : 4'b0000, (c == 12) ? 4'b0010 : 4'b0000);
         if (c == 11) check("long c11 count", 32'(count_out), 32'd9);
         if (c == 4) req = 4'b0000;
      end
`endif

      // Reset mid-interval clears everything and returns ptr to 0.
      req = 4'b1000; len[3] = 8'd50;
      for (int c = 1; c <= 5; c++) tick();
      chk_ctl("midrst", 5, 4'b1000, 4'b0000);
      rst = 1'b1;
      tick();
      chk_ctl("midrst", 6, 4'b0000, 4'b0000);
      check("midrst c6 count", 32'(count_out), 32'd0);
      rst = 1'b0; req = 4'b1001;
      tick();
      chk_ctl("midrst", 7, 4'b0001, 4'b0000);
      req = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
